// File: rtl/wb_mon_pkg.sv
// Shared types for the Wishbone B4 pipelined protocol monitor.
package wb_mon_pkg;

    localparam int NUM_VIOL = 7;
    // Storage width of a FIFO timestamp; the live timestamp width must not exceed it.
    localparam int TS_W_MAX = 16;

    typedef enum logic [2:0] {
        RSP_NO_REQ   = 3'd0,
        TIMEOUT      = 3'd1,
        STALL_CHANGE = 3'd2,
        CYC_ABORT    = 3'd3,
        OVERFLOW     = 3'd4,
        ACK_ERR_BOTH = 3'd5,
        RSP_NO_CYC   = 3'd6
    } viol_e;

    // One outstanding request: accept time, direction, and whether it has already timed out.
    typedef struct packed {
        logic [TS_W_MAX-1:0] ts;
        logic                we;
        logic                flagged;
    } ts_entry_t;

endpackage

// File: rtl/wb_mon_ts_fifo.sv
// Circular timestamp FIFO for outstanding requests: push/pop in one cycle, flush, head flag.
module wb_mon_ts_fifo
    import wb_mon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic          mark_head,
    input  ts_entry_t     din,
    output ts_entry_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ts_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Pointer/count/storage update; the caller never pops empty or pushes full without a pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            // A popped entry is gone, so marking it would be pointless.
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            else if (mark_head) mem[rd_ptr].flagged <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone B4 pipelined monitor: latency tracking, sticky violations, statistics.
module wb_protocol_monitor
    import wb_mon_pkg::*;
#(
    parameter int ADR_WIDTH       = 32,
    parameter int DAT_WIDTH       = 32,
    parameter int SEL_WIDTH       = DAT_WIDTH/8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAXWAITS        = 16,
    parameter int ALLOW_ABORT     = 1,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cyc,
    input  logic                               stb,
    input  logic                               we,
    input  logic                               stall,
    input  logic                               ack,
    input  logic                               err,
    input  logic [ADR_WIDTH-1:0]               adr,
    input  logic [SEL_WIDTH-1:0]               sel,
    input  logic [DAT_WIDTH-1:0]               dat_m,
    input  logic                               clear,
    output logic [NUM_VIOL-1:0]                viol,
    output logic                               viol_pulse,
    output logic [2:0]                         first_code,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic [$clog2(MAXWAITS+1):0]        max_latency,
    output logic [CNT_WIDTH-1:0]               rd_count,
    output logic [CNT_WIDTH-1:0]               wr_count,
    output logic [CNT_WIDTH-1:0]               err_count
);

    localparam int TW = $clog2(MAXWAITS+1) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    // Ages are computed at storage width and folded back to modulo 2^TW.
    localparam logic [TS_W_MAX-1:0] AGE_MASK = TS_W_MAX'((1 << TW) - 1);

    logic [TW-1:0]        now_ts;
    logic [TS_W_MAX-1:0]  now_ext;
    logic [TS_W_MAX-1:0]  age;
    ts_entry_t            head;
    ts_entry_t            din;
    logic                 fifo_full, fifo_empty;
    logic [OW-1:0]        fifo_count;
    logic                 accept, response, pop, push, flush, overflow, timeout_hit;
    logic                 cyc_q, stall_q, we_q, stall_chg;
    logic [ADR_WIDTH-1:0] adr_q;
    logic [SEL_WIDTH-1:0] sel_q;
    logic [DAT_WIDTH-1:0] dat_q;
    logic [NUM_VIOL-1:0]  new_viol, viol_base;
    logic [2:0]           first_sel;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept   = cyc & stb & ~stall;
    assign response = cyc & (ack | err);
    // A response against an empty FIFO is a stray and must not disturb the queue.
    assign pop      = response & ~fifo_empty;
    assign overflow = accept & fifo_full & ~pop;
    assign push     = accept & ~overflow;
    // With cyc low nothing can be in flight, so holding the flush covers every cyc fall.
    assign flush    = ~cyc;

    assign now_ext     = TS_W_MAX'(now_ts);
    assign age         = (now_ext - head.ts) & AGE_MASK;
    assign timeout_hit = ~fifo_empty & ~response & ~head.flagged & (age > TS_W_MAX'(MAXWAITS));
    assign din         = '{ts: now_ext, we: we, flagged: 1'b0};

    assign stall_chg = stall_q & (~cyc | ~stb | (adr != adr_q) | (we != we_q) |
                                  (sel != sel_q) | (we_q & (dat_m != dat_q)));

    assign outstanding = fifo_count;

    wb_mon_ts_fifo #(.DEPTH(MAX_OUTSTANDING), .CW(OW)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .mark_head (timeout_hit),
        .din       (din),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Collect this cycle's violations and pick the lowest-index code as the first one.
    always_comb begin
        new_viol               = '0;
        new_viol[RSP_NO_REQ]   = response & fifo_empty;
        new_viol[TIMEOUT]      = timeout_hit;
        new_viol[STALL_CHANGE] = stall_chg;
        new_viol[CYC_ABORT]    = (ALLOW_ABORT == 0) & cyc_q & ~cyc & (fifo_count != '0);
        new_viol[OVERFLOW]     = overflow;
        new_viol[ACK_ERR_BOTH] = ack & err;
        new_viol[RSP_NO_CYC]   = (ack | err) & ~cyc;
        viol_base              = clear ? '0 : viol;
        first_sel              = '0;
        for (int i = NUM_VIOL-1; i >= 0; i--) begin
            if (new_viol[i]) first_sel = 3'(i);
        end
    end

    // Free-running timestamp plus the one-cycle history used by stall and cyc checks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            now_ts  <= '0;
            cyc_q   <= 1'b0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
        end else begin
            now_ts  <= now_ts + 1'b1;
            cyc_q   <= cyc;
            stall_q <= cyc & stb & stall;
            we_q    <= we;
            adr_q   <= adr;
            sel_q   <= sel;
            dat_q   <= dat_m;
        end
    end

    // Sticky violations; new violations win over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            viol       <= '0;
            viol_pulse <= 1'b0;
            first_code <= '0;
        end else begin
            viol       <= viol_base | new_viol;
            viol_pulse <= |(new_viol & ~viol_base);
            if ((viol_base == '0) && (new_viol != '0)) first_code <= first_sel;
            else if (clear)                           first_code <= '0;
        end
    end

    // Completion statistics and worst-case latency, updated on each popped response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_latency <= '0;
            rd_count    <= '0;
            wr_count    <= '0;
            err_count   <= '0;
        end else if (clear) begin
            max_latency <= '0;
            rd_count    <= '0;
            wr_count    <= '0;
            err_count   <= '0;
        end else if (pop) begin
            if (age > TS_W_MAX'(max_latency)) max_latency <= age[TW-1:0];
            if (head.we) wr_count <= sat_inc(wr_count);
            else         rd_count <= sat_inc(rd_count);
            if (err)     err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Directed bench for wb_protocol_monitor (MAX_OUTSTANDING=4, MAXWAITS=16, ALLOW_ABORT=0).
module tb_wb_protocol_monitor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cyc = 0, stb = 0, we = 0, stall = 0, ack = 0, err = 0, clear = 0;
    logic [31:0] adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_m = '0;
    logic [6:0]  viol;
    logic        viol_pulse;
    logic [2:0]  first_code;
    logic [2:0]  outstanding;
    logic [5:0]  max_latency;
    logic [31:0] rd_count, wr_count, err_count;

    int n_cmp = 0;
    int n_err = 0;

    wb_protocol_monitor #(
        .ADR_WIDTH(32), .DAT_WIDTH(32), .SEL_WIDTH(4), .MAX_OUTSTANDING(4),
        .MAXWAITS(16), .ALLOW_ABORT(0), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cyc(cyc), .stb(stb), .we(we), .stall(stall),
        .ack(ack), .err(err), .adr(adr), .sel(sel), .dat_m(dat_m), .clear(clear),
        .viol(viol), .viol_pulse(viol_pulse), .first_code(first_code),
        .outstanding(outstanding), .max_latency(max_latency),
        .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc = 0; stb = 0; we = 0; stall = 0; ack = 0; err = 0; clear = 0;
        adr = '0; sel = '0; dat_m = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        step(); step();
        reset_n = 1;
        step();
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        step();
        n_cmp++; if ({viol, viol_pulse, first_code} !== 11'd0) begin n_err++;
            $display("FAIL reset_flags: got %h want 0", {viol, viol_pulse, first_code}); end
        n_cmp++; if ({outstanding, max_latency} !== 9'd0) begin n_err++;
            $display("FAIL reset_occ: got %h want 0", {outstanding, max_latency}); end
        n_cmp++; if ({rd_count, wr_count, err_count} !== 96'd0) begin n_err++;
            $display("FAIL reset_cnt: got %h want 0", {rd_count, wr_count, err_count}); end
        reset_n = 1;
        step();
    endtask

    task automatic test_single_read();
        do_reset();
        cyc = 1; stb = 1; we = 0; adr = 32'h40; sel = 4'hF;   // cycle 0 accept
        step();
        n_cmp++; if (outstanding !== 3'd1) begin n_err++;
            $display("FAIL single_out1: got %0d want 1", outstanding); end
        stb = 0;
        step(); step();                                     // cycles 1, 2
        ack = 1;                                            // cycle 3
        step();
        ack = 0;
        n_cmp++; if (viol !== 7'd0) begin n_err++;
            $display("FAIL single_viol: got %b want 0", viol); end
        n_cmp++; if (rd_count !== 32'd1) begin n_err++;
            $display("FAIL single_rd: got %0d want 1", rd_count); end
        n_cmp++; if (max_latency !== 6'd3) begin n_err++;
            $display("FAIL single_lat: got %0d want 3", max_latency); end
        n_cmp++; if (outstanding !== 3'd0) begin n_err++;
            $display("FAIL single_out0: got %0d want 0", outstanding); end
        cyc = 0;
        step();
        n_cmp++; if (viol !== 7'd0) begin n_err++;
            $display("FAIL single_cycdrop: got %b want 0", viol); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_out [6];
        exp_out = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0};
        do_reset();
        cyc = 1; we = 1; sel = 4'hF;
        for (int c = 0; c < 6; c++) begin
            stb   = (c < 4);
            adr   = 32'h200 + 32'(c * 4);
            dat_m = 32'hA000 + 32'(c);
            ack   = (c >= 2);
            step();
            n_cmp++; if (outstanding !== exp_out[c]) begin n_err++;
                $display("FAIL burst_out_c%0d: got %0d want %0d", c, outstanding, exp_out[c]); end
        end
        idle();
        n_cmp++; if (wr_count !== 32'd4) begin n_err++;
            $display("FAIL burst_wr: got %0d want 4", wr_count); end
        n_cmp++; if (viol !== 7'd0) begin n_err++;
            $display("FAIL burst_viol: got %b want 0", viol); end
        n_cmp++; if (max_latency !== 6'd2) begin n_err++;
            $display("FAIL burst_lat: got %0d want 2", max_latency); end
        step();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        do_reset();
        cyc = 1; stb = 1; we = 0;                           // cycle 0 accept
        step();
        if (viol_pulse) pulses++;
        stb = 0;
        for (int i = 2; i <= 25; i++) begin
            step();
            if (viol_pulse) pulses++;
            if (i == 17) begin
                n_cmp++; if (viol !== 7'd0) begin n_err++;
                    $display("FAIL timeout_early: got %b want 0", viol); end
            end
            if (i == 18) begin
                n_cmp++; if (viol !== 7'b0000010) begin n_err++;
                    $display("FAIL timeout_viol: got %b want 0000010", viol); end
            end
        end
        n_cmp++; if (first_code !== 3'd1) begin n_err++;
            $display("FAIL timeout_code: got %0d want 1", first_code); end
        n_cmp++; if (pulses !== 1) begin n_err++;
            $display("FAIL timeout_pulses: got %0d want 1", pulses); end
        ack = 1;                                            // cycle 25
        step();
        idle();
        n_cmp++; if (max_latency !== 6'd25 || rd_count !== 32'd1) begin n_err++;
            $display("FAIL timeout_lat: got %0d/%0d want 25/1", max_latency, rd_count); end
        step();
    endtask

    task automatic test_stall_change();
        do_reset();
        cyc = 1; stb = 1; stall = 1; adr = 32'h100; sel = 4'hF;
        step();
        adr = 32'h104;
        step();
        n_cmp++; if (viol !== 7'b0000100 || first_code !== 3'd2) begin n_err++;
            $display("FAIL stall_chg: got %b/%0d want 0000100/2", viol, first_code); end

        do_reset();
        cyc = 1; stb = 1; stall = 1; adr = 32'h100; sel = 4'hF;
        step();
        step();
        n_cmp++; if (viol !== 7'd0) begin n_err++;
            $display("FAIL stall_hold: got %b want 0", viol); end
        stall = 0;                                          // accepted
        step();
        stb = 0;
        step();
        ack = 1;
        step();
        ack = 0; cyc = 0;
        step();
        n_cmp++; if (viol !== 7'd0 || rd_count !== 32'd1 || outstanding !== 3'd0) begin n_err++;
            $display("FAIL stall_clean: got %b/%0d/%0d want 0/1/0", viol, rd_count, outstanding); end
    endtask

    task automatic test_overflow();
        do_reset();
        cyc = 1; stb = 1; we = 0;
        for (int c = 0; c < 4; c++) begin adr = 32'(c); step(); end
        n_cmp++; if (outstanding !== 3'd4) begin n_err++;
            $display("FAIL ovf_full: got %0d want 4", outstanding); end
        adr = 32'h4;
        step();                                             // fifth accept
        n_cmp++; if (viol !== 7'b0010000 || outstanding !== 3'd4) begin n_err++;
            $display("FAIL ovf_viol: got %b/%0d want 0010000/4", viol, outstanding); end
        stb = 0; ack = 1;
        for (int c = 0; c < 4; c++) step();
        n_cmp++; if (outstanding !== 3'd0 || rd_count !== 32'd4 || max_latency !== 6'd5) begin n_err++;
            $display("FAIL ovf_drain: got %0d/%0d/%0d want 0/4/5", outstanding, rd_count, max_latency); end
        step();                                             // stray ack
        ack = 0;
        n_cmp++; if (viol !== 7'b0010001 || first_code !== 3'd4 || rd_count !== 32'd4) begin n_err++;
            $display("FAIL ovf_stray: got %b/%0d/%0d want 0010001/4/4", viol, first_code, rd_count); end
        idle();
        step();
    endtask

    task automatic test_ack_err();
        do_reset();
        cyc = 1; stb = 1; we = 0;
        step();
        stb = 0;
        step();
        ack = 1; err = 1;
        step();
        ack = 0; err = 0;
        n_cmp++; if (viol !== 7'b0100000 || first_code !== 3'd5) begin n_err++;
            $display("FAIL both_viol: got %b/%0d want 0100000/5", viol, first_code); end
        n_cmp++; if (rd_count !== 32'd1 || err_count !== 32'd1) begin n_err++;
            $display("FAIL both_cnt: got %0d/%0d want 1/1", rd_count, err_count); end
        step();
        cyc = 0; ack = 1;
        step();
        ack = 0;
        n_cmp++; if (viol !== 7'b1100000 || first_code !== 3'd5 || viol_pulse !== 1'b1) begin n_err++;
            $display("FAIL nocyc_viol: got %b/%0d/%b want 1100000/5/1", viol, first_code, viol_pulse); end
        step();
    endtask

    task automatic test_min_latency();
        do_reset();
        cyc = 1; stb = 1; ack = 1;                          // accept and ack together
        step();
        n_cmp++; if (viol !== 7'b0000001 || outstanding !== 3'd1 || rd_count !== 32'd0) begin n_err++;
            $display("FAIL minlat_stray: got %b/%0d/%0d want 0000001/1/0", viol, outstanding, rd_count); end
        stb = 0;
        step();
        ack = 0;
        n_cmp++; if (rd_count !== 32'd1 || outstanding !== 3'd0 || max_latency !== 6'd1) begin n_err++;
            $display("FAIL minlat_pop: got %0d/%0d/%0d want 1/0/1", rd_count, outstanding, max_latency); end
        idle();
        step();
    endtask

    task automatic test_abort_clear();
        do_reset();
        cyc = 1; stb = 1; we = 1;
        step();
        ack = 1;                                            // accept + pop
        step();
        ack = 0;
        step();
        n_cmp++; if (outstanding !== 3'd2 || wr_count !== 32'd1) begin n_err++;
            $display("FAIL abort_pre: got %0d/%0d want 2/1", outstanding, wr_count); end
        cyc = 0; stb = 0;
        step();
        n_cmp++; if (viol !== 7'b0001000 || first_code !== 3'd3 || outstanding !== 3'd0) begin n_err++;
            $display("FAIL abort_viol: got %b/%0d/%0d want 0001000/3/0", viol, first_code, outstanding); end
        clear = 1;
        step();
        clear = 0;
        n_cmp++; if (viol !== 7'd0 || first_code !== 3'd0) begin n_err++;
            $display("FAIL clear_flags: got %b/%0d want 0/0", viol, first_code); end
        n_cmp++; if (wr_count !== 32'd0 || max_latency !== 6'd0) begin n_err++;
            $display("FAIL clear_stats: got %0d/%0d want 0/0", wr_count, max_latency); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc = 1; stb = 1; we = 1;
        step();
        ack = 1;
        step();
        err = 1;                                            // ack+err, still accepting
        step();
        n_cmp++; if (wr_count !== 32'd2 || err_count !== 32'd1 || outstanding !== 3'd1) begin n_err++;
            $display("FAIL mid_pre: got %0d/%0d/%0d want 2/1/1", wr_count, err_count, outstanding); end
        #2 reset_n = 0;
        #1;
        n_cmp++; if ({viol, viol_pulse, first_code, outstanding, max_latency} !== 20'd0) begin n_err++;
            $display("FAIL mid_flags: got %h want 0", {viol, viol_pulse, first_code, outstanding, max_latency}); end
        n_cmp++; if ({rd_count, wr_count, err_count} !== 96'd0) begin n_err++;
            $display("FAIL mid_cnt: got %h want 0", {rd_count, wr_count, err_count}); end
        idle();
        step();
        reset_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_timeout();
        test_stall_change();
        test_overflow();
        test_ack_err();
        test_min_latency();
        test_abort_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
